// File: rtl/param_setting_mode_pkg.sv
// Shared constants for the parameter-setting mode: ASCII control bytes, error codes,
// FSM state encodings and a small byte classifier.
package param_setting_mode_pkg;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;
  localparam logic [7:0] ASCII_BANG = 8'h21;
  localparam logic [7:0] ASCII_S    = 8'h53;

  localparam logic [3:0] ERR_NONE        = 4'h0;
  localparam logic [3:0] ERR_VALUE_RANGE = 4'h2;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PROMPT   = 4'd1,
    ST_COLLECT  = 4'd2,
    ST_CHECK    = 4'd3,
    ST_ERR_SEND = 4'd4,
    ST_NEXT     = 4'd5,
    ST_CONFIRM  = 4'd6,
    ST_DONE     = 4'd7
  } state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/param_setting_mode_tx_arbiter.sv
// Serialises echo, status and prompt bytes onto a single transmitter handshake.
// Echo has top priority so a pending digit always leaves before the next prompt or status.
module setting_tx_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       tx_busy,
  input  logic       echo_req,
  input  logic [7:0] echo_byte,
  input  logic       status_req,
  input  logic [7:0] status_byte,
  input  logic       prompt_req,
  input  logic [7:0] prompt_byte,
  output logic       echo_grant,
  output logic       status_grant,
  output logic       prompt_grant,
  output logic [7:0] tx_data,
  output logic       tx_start
);

  logic slot_free_s;

  // Grant at most one requester when the transmitter is idle and no start is in flight
  always_comb begin
    slot_free_s  = enable && !tx_busy && !tx_start;
    echo_grant   = 1'b0;
    status_grant = 1'b0;
    prompt_grant = 1'b0;
    if (slot_free_s && echo_req) begin
      echo_grant = 1'b1;
    end else if (slot_free_s && status_req) begin
      status_grant = 1'b1;
    end else if (slot_free_s && prompt_req) begin
      prompt_grant = 1'b1;
    end else begin
      echo_grant = 1'b0;
    end
  end

  // Registered transmit strobe and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= echo_grant | status_grant | prompt_grant;
      if (echo_grant) begin
        tx_data <= echo_byte;
      end else if (status_grant) begin
        tx_data <= status_byte;
      end else if (prompt_grant) begin
        tx_data <= prompt_byte;
      end else begin
        tx_data <= tx_data;
      end
    end
  end

endmodule

// File: rtl/param_setting_mode.sv
// Serial parameter entry: prompt per field, collect decimal digits, range-check, commit all
// fields atomically. Optional digit echo is enabled by defining SETTING_ECHO_EN.
module param_setting_mode
  import param_setting_mode_pkg::*;
#(
  parameter int NUM_FIELDS  = 3,
  parameter int VALUE_WIDTH = 8,
  parameter int MAX_DIGITS  = 3,
  parameter logic [NUM_FIELDS*VALUE_WIDTH-1:0] FIELD_MIN     = 24'h010101,
  parameter logic [NUM_FIELDS*VALUE_WIDTH-1:0] FIELD_MAX     = 24'h14FF05,
  parameter logic [NUM_FIELDS*VALUE_WIDTH-1:0] FIELD_DEFAULT = 24'h0A6402,
  parameter logic [NUM_FIELDS*8-1:0]           FIELD_PROMPT  = 24'h4D5644
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mode_active,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_done,
  output logic                              clear_rx_buffer,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  input  logic                              tx_busy,
  output logic [NUM_FIELDS*VALUE_WIDTH-1:0] config_values,
  output logic                              config_valid,
  output logic [3:0]                        error_code,
  output logic [2:0]                        field_idx,
  output logic [3:0]                        sub_state
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 2);
  localparam int FW     = NUM_FIELDS * VALUE_WIDTH;

  state_e                 state_r;
  logic [2:0]             field_idx_r;
  logic [VALUE_WIDTH-1:0] accum_r;
  logic [DCNT_W-1:0]      digit_cnt_r;
  logic                   ovf_r;
  logic [FW-1:0]          staging_r;
  logic [FW-1:0]          config_values_r;
  logic                   config_valid_r;
  logic [3:0]             error_code_r;
  logic                   clear_rx_r;

  logic [VALUE_WIDTH+3:0] accum_ext_s;
  logic [VALUE_WIDTH+3:0] accum_next_s;
  logic                   digit_fits_s;
  logic [VALUE_WIDTH-1:0] min_s;
  logic [VALUE_WIDTH-1:0] max_s;
  logic                   value_ok_s;
  logic                   rx_take_s;
  logic                   echo_req_s;
  logic [7:0]             echo_byte_s;
  logic                   echo_grant_s;
  logic                   status_grant_s;
  logic                   prompt_grant_s;
  logic                   status_req_s;
  logic [7:0]             status_byte_s;
  logic                   prompt_req_s;
  logic [7:0]             prompt_byte_s;

`ifdef SETTING_ECHO_EN
  logic       echo_pending_r;
  logic [7:0] echo_data_r;
  assign echo_req_s  = echo_pending_r;
  assign echo_byte_s = echo_data_r;
`else
  assign echo_req_s  = 1'b0;
  assign echo_byte_s = 8'h00;
`endif

  // Decimal shift-add step, field bounds and request decode for the arbiter
  always_comb begin
    accum_ext_s   = {4'b0000, accum_r};
    accum_next_s  = (accum_ext_s << 3) + (accum_ext_s << 1)
                  + {{VALUE_WIDTH{1'b0}}, rx_data[3:0]};
    digit_fits_s  = accum_next_s <= {4'b0000, {VALUE_WIDTH{1'b1}}};
    min_s         = FIELD_MIN[field_idx_r*VALUE_WIDTH +: VALUE_WIDTH];
    max_s         = FIELD_MAX[field_idx_r*VALUE_WIDTH +: VALUE_WIDTH];
    value_ok_s    = !ovf_r && (digit_cnt_r != '0) && (accum_r >= min_s) && (accum_r <= max_s);
    // A pending echo stalls reception so the one-entry echo slot can never be overrun
    rx_take_s     = mode_active && (state_r == ST_COLLECT) && rx_done && !clear_rx_r && !echo_req_s;
    status_req_s  = mode_active && ((state_r == ST_ERR_SEND) || (state_r == ST_CONFIRM));
    status_byte_s = (state_r == ST_CONFIRM) ? ASCII_S : ASCII_BANG;
    prompt_req_s  = mode_active && (state_r == ST_PROMPT);
    prompt_byte_s = FIELD_PROMPT[field_idx_r*8 +: 8];
  end

  setting_tx_arbiter u_tx_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (mode_active),
    .tx_busy      (tx_busy),
    .echo_req     (echo_req_s),
    .echo_byte    (echo_byte_s),
    .status_req   (status_req_s),
    .status_byte  (status_byte_s),
    .prompt_req   (prompt_req_s),
    .prompt_byte  (prompt_byte_s),
    .echo_grant   (echo_grant_s),
    .status_grant (status_grant_s),
    .prompt_grant (prompt_grant_s),
    .tx_data      (tx_data),
    .tx_start     (tx_start)
  );

  // Session FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      field_idx_r     <= 3'd0;
      accum_r         <= '0;
      digit_cnt_r     <= '0;
      ovf_r           <= 1'b0;
      staging_r       <= FIELD_DEFAULT;
      config_values_r <= FIELD_DEFAULT;
      config_valid_r  <= 1'b0;
      error_code_r    <= ERR_NONE;
      clear_rx_r      <= 1'b0;
`ifdef SETTING_ECHO_EN
      echo_pending_r  <= 1'b0;
      echo_data_r     <= 8'h00;
`endif
    end else begin
      clear_rx_r     <= 1'b0;
      config_valid_r <= 1'b0;
`ifdef SETTING_ECHO_EN
      if (echo_grant_s) echo_pending_r <= 1'b0;
`endif
      if (!mode_active) begin
        state_r     <= ST_IDLE;
        field_idx_r <= 3'd0;
        accum_r     <= '0;
        digit_cnt_r <= '0;
        ovf_r       <= 1'b0;
`ifdef SETTING_ECHO_EN
        echo_pending_r <= 1'b0;
`endif
      end else begin
        case (state_r)
          ST_IDLE: begin
            staging_r   <= config_values_r;
            accum_r     <= '0;
            digit_cnt_r <= '0;
            ovf_r       <= 1'b0;
            field_idx_r <= 3'd0;
            state_r     <= ST_PROMPT;
          end
          ST_PROMPT: begin
            if (prompt_grant_s) state_r <= ST_COLLECT;
          end
          ST_COLLECT: begin
            if (rx_take_s) begin
              clear_rx_r <= 1'b1;
              if (is_digit(rx_data)) begin
                if (ovf_r) begin
                  ovf_r <= 1'b1;
                end else if ((digit_cnt_r >= DCNT_W'(MAX_DIGITS)) || !digit_fits_s) begin
                  ovf_r <= 1'b1;
                end else begin
                  accum_r     <= accum_next_s[VALUE_WIDTH-1:0];
                  digit_cnt_r <= digit_cnt_r + 1'b1;
`ifdef SETTING_ECHO_EN
                  echo_pending_r <= 1'b1;
                  echo_data_r    <= rx_data;
`endif
                end
              end else if ((rx_data == ASCII_CR) || (rx_data == ASCII_LF)) begin
                state_r <= ST_CHECK;
              end else if (rx_data == ASCII_ESC) begin
                error_code_r <= ERR_NONE;
                state_r      <= ST_IDLE;
              end else begin
                state_r <= ST_COLLECT;
              end
            end
          end
          ST_CHECK: begin
            if (value_ok_s) begin
              staging_r[field_idx_r*VALUE_WIDTH +: VALUE_WIDTH] <= accum_r;
              state_r <= ST_NEXT;
            end else begin
              error_code_r <= ERR_VALUE_RANGE;
              state_r      <= ST_ERR_SEND;
            end
          end
          ST_ERR_SEND: begin
            if (status_grant_s) begin
              accum_r     <= '0;
              digit_cnt_r <= '0;
              ovf_r       <= 1'b0;
              state_r     <= ST_PROMPT;
            end
          end
          ST_NEXT: begin
            accum_r     <= '0;
            digit_cnt_r <= '0;
            ovf_r       <= 1'b0;
            if (field_idx_r == 3'(NUM_FIELDS - 1)) begin
              state_r <= ST_CONFIRM;
            end else begin
              field_idx_r <= field_idx_r + 3'd1;
              state_r     <= ST_PROMPT;
            end
          end
          ST_CONFIRM: begin
            if (status_grant_s) begin
              config_values_r <= staging_r;
              config_valid_r  <= 1'b1;
              error_code_r    <= ERR_NONE;
              state_r         <= ST_DONE;
            end
          end
          ST_DONE: state_r <= ST_IDLE;
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign clear_rx_buffer = clear_rx_r;
  assign config_values   = config_values_r;
  assign config_valid    = config_valid_r;
  assign error_code      = error_code_r;
  assign field_idx       = field_idx_r;
  assign sub_state       = state_r;

endmodule
